// File: rtl/uart_tx_frame.sv
// UART frame serializer: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// One bit per baud_tick; frame fields are captured at the valid/ready handshake.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  baud_tick,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [1:0]            parity_type,
  input  logic                  parity_in,
  input  logic                  stop_bits,
  output logic                  tx_out,
  output logic                  tx_busy,
  output logic                  tx_done,
  output logic [2:0]            state_dbg
);

  // Handshake: a transfer happens at a rising edge where tx_valid && tx_ready;
  // tx_ready is high only in IDLE and valid while busy is simply ignored.

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } state_t;

  state_t                  state, state_n;
  logic [IDX_W-1:0]        bit_idx, bit_idx_n;
  logic                    stop_idx, stop_idx_n;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [1:0]              ptype_q;
  logic                    par_q;
  logic                    stop_q;
  logic                    line_n;
  logic                    done_n;
  logic                    accept;
  logic                    par_en;

  assign accept  = tx_valid && (state == S_IDLE);
  assign par_en  = (ptype_q == 2'b01) || (ptype_q == 2'b10);

  always_comb begin
    state_n    = state;
    bit_idx_n  = bit_idx;
    stop_idx_n = stop_idx;
    done_n     = 1'b0;
    case (state)
      S_IDLE: begin
        if (tx_valid) state_n = S_ARM;
      end
      // ARM absorbs any tick coinciding with acceptance so the start bit is a full period.
      S_ARM: begin
        if (baud_tick) state_n = S_START;
      end
      S_START: begin
        if (baud_tick) begin
          state_n   = S_DATA;
          bit_idx_n = '0;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          if (bit_idx == LAST_IDX) begin
            if (par_en) begin
              state_n = S_PARITY;
            end else begin
              state_n    = S_STOP;
              stop_idx_n = 1'b0;
            end
          end else begin
            bit_idx_n = bit_idx + IDX_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (baud_tick) begin
          state_n    = S_STOP;
          stop_idx_n = 1'b0;
        end
      end
      S_STOP: begin
        if (baud_tick) begin
          if (!stop_idx && stop_q) begin
            stop_idx_n = 1'b1;
          end else begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Line value is derived from the next state so tx_out moves with the state register.
    case (state_n)
      S_START:  line_n = 1'b0;
      S_DATA:   line_n = data_q[bit_idx_n];
      S_PARITY: line_n = par_q;
      default:  line_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      tx_out   <= 1'b1;
      tx_done  <= 1'b0;
      data_q   <= '0;
      ptype_q  <= 2'b00;
      par_q    <= 1'b0;
      stop_q   <= 1'b0;
    end else begin
      state    <= state_n;
      bit_idx  <= bit_idx_n;
      stop_idx <= stop_idx_n;
      tx_out   <= line_n;
      tx_done  <= done_n;
      if (accept) begin
        data_q  <= data_in;
        ptype_q <= parity_type;
        par_q   <= parity_in;
        stop_q  <= stop_bits;
      end
    end
  end

  assign tx_ready  = (state == S_IDLE);
  assign tx_busy   = (state != S_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: frame-level bit-queue model checked every cycle,
// directed frames pinned against hand-written bit sequences, then random frames.
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_tick;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] data_in;
  logic [1:0] parity_type;
  logic       parity_in;
  logic       stop_bits;
  logic       tx_out;
  logic       tx_busy;
  logic       tx_done;
  logic [2:0] state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  int n_print = 0;
  int tick_span = 2;
  int done_cnt = 0;
  bit check_en = 1'b0;

  uart_tx_frame #(.DATA_WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .baud_tick   (baud_tick),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .data_in     (data_in),
    .parity_type (parity_type),
    .parity_in   (parity_in),
    .stop_bits   (stop_bits),
    .tx_out      (tx_out),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset / tick ----------------
  always #5 clk = ~clk;

  initial begin
    baud_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      baud_tick = ($urandom_range(0, tick_span) == 0);
    end
  end

  // ---------------- behavioural model ----------------
  // A frame is just a queue of line bits; each tick while busy shows the next one.
  logic        exp_q[$];
  logic        m_busy = 1'b0;
  logic        m_line = 1'b1;
  logic        m_done = 1'b0;
  int          m_popped = 0;
  logic [15:0] m_log = '0;
  int          m_len = 0;
  logic [15:0] m_last_bits = '0;
  int          m_last_len = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0;
      m_line = 1'b1;
      m_done = 1'b0;
      exp_q.delete();
      m_popped = 0;
    end else begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (tx_valid) begin
          exp_q.delete();
          exp_q.push_back(1'b0);
          for (int i = 0; i < 8; i++) exp_q.push_back(data_in[i]);
          if (parity_type == 2'b01 || parity_type == 2'b10) exp_q.push_back(parity_in);
          exp_q.push_back(1'b1);
          if (stop_bits) exp_q.push_back(1'b1);
          m_busy = 1'b1;
          m_popped = 0;
          m_log = '0;
          m_len = 0;
        end
      end else if (baud_tick) begin
        if (exp_q.size() > 0) begin
          m_line = exp_q.pop_front();
          m_log[m_len] = m_line;
          m_len++;
          m_popped++;
        end else begin
          m_busy = 1'b0;
          m_line = 1'b1;
          m_done = 1'b1;
          m_last_bits = m_log;
          m_last_len = m_len;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (tx_done === 1'b1) done_cnt++;
    if (check_en) begin
      n_tests++;
      if (tx_out !== m_line || tx_busy !== m_busy || tx_ready !== !m_busy || tx_done !== m_done) begin
        n_fail++;
        if (n_print < 20) begin
          n_print++;
          $display("FAIL cycle_cmp t=%0t: out/busy/ready/done got %b%b%b%b expected %b%b%b%b",
                   $time, tx_out, tx_busy, tx_ready, tx_done, m_line, m_busy, !m_busy, m_done);
        end
      end
    end
  end

  // ---------------- driver tasks / checks ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic start_frame(input logic [7:0] d, input logic [1:0] pt, input logic pi,
                             input logic sb, input bit same_tick);
    int n = 0;
    @(posedge clk); #2;
    while (!(tx_ready && (!same_tick || baud_tick))) begin
      n++;
      if (n > 3000) begin
        timeout_fail("wait_ready");
        return;
      end
      @(posedge clk); #2;
    end
    tx_valid = 1'b1;
    data_in = d;
    parity_type = pt;
    parity_in = pi;
    stop_bits = sb;
    @(posedge clk); #2;
    tx_valid = 1'b0;
    // Scramble the inputs; the frame in flight must not change.
    data_in = 8'($urandom);
    parity_type = 2'($urandom);
    parity_in = 1'($urandom);
    stop_bits = 1'($urandom);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (tx_done !== 1'b1) begin
      n++;
      if (n > 5000) begin
        timeout_fail(name);
        return;
      end
      @(posedge clk); #2;
    end
  endtask

  task automatic check_frame(input string name, input int bits, input int len);
    chk({name, "_bits"}, int'(m_last_bits), bits);
    chk({name, "_len"}, m_last_len, len);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int d0;
    int ready_cnt;
    int n;
    rst = 1'b1;
    tx_valid = 1'b0;
    data_in = 8'h00;
    parity_type = 2'b00;
    parity_in = 1'b0;
    stop_bits = 1'b0;

    @(posedge clk); #2;
    check_en = 1'b1;
    chk("rst_tx_out", int'(tx_out), 1);
    chk("rst_busy", int'(tx_busy), 0);
    chk("rst_ready", int'(tx_ready), 1);
    chk("rst_done", int'(tx_done), 0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;
    chk("post_rst_tx_out", int'(tx_out), 1);
    chk("post_rst_busy", int'(tx_busy), 0);
    chk("post_rst_ready", int'(tx_ready), 1);

    // No parity, one stop bit.
    d0 = done_cnt;
    start_frame(8'hA5, 2'b00, 1'b0, 1'b0, 1'b0);
    wait_done("no_parity");
    check_frame("no_parity", 'h34A, 10);
    repeat (3) @(posedge clk);
    #2;
    chk("no_parity_done_pulses", done_cnt - d0, 1);

    // Even parity, two stop bits.
    start_frame(8'h01, 2'b10, 1'b1, 1'b1, 1'b0);
    wait_done("even_parity");
    check_frame("even_parity", 'hE02, 12);

    // Odd parity bit 0, then type 11 (no parity slot).
    start_frame(8'h01, 2'b01, 1'b0, 1'b0, 1'b0);
    wait_done("odd_parity");
    check_frame("odd_parity", 'h402, 11);
    start_frame(8'h01, 2'b11, 1'b1, 1'b0, 1'b0);
    wait_done("type11");
    check_frame("type11", 'h202, 10);

    // Acceptance coinciding with a tick.
    start_frame(8'h0F, 2'b00, 1'b0, 1'b0, 1'b1);
    wait_done("same_tick");
    check_frame("same_tick", 'h21E, 10);

    // Input change mid-frame.
    start_frame(8'h81, 2'b00, 1'b0, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    #2;
    data_in = 8'hFF;
    wait_done("data_change");
    check_frame("data_change", 'h302, 10);

    // Back-to-back with tx_valid held high.
    @(posedge clk); #2;
    tx_valid = 1'b1;
    data_in = 8'h3C;
    parity_type = 2'b00;
    stop_bits = 1'b0;
    n = 0;
    while (!tx_ready && n < 3000) begin
      n++;
      @(posedge clk); #2;
    end
    @(posedge clk); #2;
    data_in = 8'hC3;
    wait_done("b2b_first");
    check_frame("b2b_first", 'h278, 10);
    ready_cnt = 0;
    while (tx_ready && ready_cnt < 100) begin
      ready_cnt++;
      @(posedge clk); #2;
    end
    tx_valid = 1'b0;
    chk("b2b_ready_cycles", ready_cnt, 1);
    wait_done("b2b_second");
    check_frame("b2b_second", 'h386, 10);

    // Reset during data bit 3.
    start_frame(8'hE7, 2'b10, 1'b1, 1'b1, 1'b0);
    n = 0;
    while (m_popped != 5 && n < 3000) begin
      n++;
      @(posedge clk); #2;
    end
    if (n >= 3000) timeout_fail("wait_data3");
    rst = 1'b1;
    d0 = done_cnt;
    @(posedge clk); #2;
    chk("midrst_tx_out", int'(tx_out), 1);
    chk("midrst_busy", int'(tx_busy), 0);
    chk("midrst_ready", int'(tx_ready), 1);
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    chk("midrst_no_done", done_cnt - d0, 0);
    start_frame(8'h55, 2'b00, 1'b0, 1'b0, 1'b0);
    wait_done("after_rst");
    check_frame("after_rst", 'h2AA, 10);

    // Random frames with random tick density.
    for (int k = 0; k < 40; k++) begin
      tick_span = $urandom_range(0, 4);
      start_frame(8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) wait_done("random");
    end
    wait_done("random_last");
    repeat (5) @(posedge clk);
    #2;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
